fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the single-issue MIPS core. Owns the program counter, drives the PC into the combinational instruction memory, captures the returned instruction into the IF/ID pipeline register, and computes next-PC for sequential flow, conditional branches, `j` and `jr`. Sits between decode (which supplies stall and redirect requests) and the instruction memory (which consumes `pc`).

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC and IF/ID contents (load-use hazard from decode).
- `flush`  in  1  replace IF/ID contents with a bubble at the next edge.
- `br_taken`  in  1  conditional branch in ID resolved taken.
- `br_imm`  in  16  branch immediate of the instruction in ID, in words.
- `j_en`  in  1  `j`/`jal` in ID.
- `j_index`  in  26  jump index field.
- `jr_en`  in  1  `jr`/`jalr` in ID.
- `jr_target`  in  32  register value for `jr`.
- `imem_instr`  in  32  instruction word returned for `pc`, same cycle.
- `pc`  out  32  current fetch address to instruction memory.
- `if_id_instr`  out  32  registered instruction.
- `if_id_pc4`  out  32  registered fetch PC + 4.
- `if_id_valid`  out  1  IF/ID holds a real instruction.

## Operation
- Reset values: `pc`=RESET_PC, `if_id_instr`=32'h0 (NOP), `if_id_pc4`=0, `if_id_valid`=0; counters (if compiled) = 0.
- Next-PC selection, priority high to low: `rst` > `jr_en` > `j_en` > `br_taken` > `stall` > sequential.
  - jr: `{jr_target[31:2],2'b00}`; low two bits ignored.
  - j: `{if_id_pc4[31:28], j_index, 2'b00}`.
  - branch: `if_id_pc4 + (sign_extend(br_imm) << 2)`, modulo 2^32.
  - stall: PC unchanged.
  - sequential: `pc + 4`, wraps 32'hFFFF_FFFC -> 0.
- IF/ID update at each edge:
  - Redirect (any of jr/j/branch) or `flush`: bubble (instr=0, pc4=0, valid=0). No delay slot; the wrong-path instruction is discarded.
  - Else `stall`: hold all IF/ID fields.
  - Else: instr=`imem_instr`, pc4=`pc+4`, valid=1.
- Redirect wins over `stall` if both are asserted. Decode must not assert redirects during a stall; the unit does not check this.
- If more than one redirect is asserted, the priority above applies. Not a legal decode state; no error output.

## Timing
- `pc` is registered. Instruction memory is combinational, so `imem_instr` for `pc` is valid in the same cycle.
- Fetch latency: instruction at `pc` appears on `if_id_*` one edge later.
- Redirect asserted in cycle n:
  - `pc` = target in n+1.
  - IF/ID = bubble in n+1.
  - Target instruction is in IF/ID in n+2.
- Stall asserted for k cycles: `pc` and IF/ID frozen for exactly k edges; sequential fetch resumes on the first edge with `stall`=0.
- `rst` mid-stream: all state returns to reset values at that edge regardless of other inputs. The first fetch after release is RESET_PC.

## Configuration
- `FETCH_PERF_CNT_EN` defined adds two ports:
  - `fetch_count` out 32: increments on each edge that loads a valid instruction into IF/ID.
  - `redirect_count` out 32: increments on each redirect edge.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `mips_pkg` holds:
  - `NOP_INSTR` = 32'h0 and `DEFAULT_RESET_PC`.
  - The next-PC select encoding (SEQ, HOLD, BRANCH, JUMP, JR) as localparams.
- One sub-module, `next_pc_sel`: purely combinational priority encoder plus target arithmetic. `fetch_unit` holds only the registers and the optional counters.

## Test plan
- Reset then 4 free-running cycles: `pc` = 0x0, 0x4, 0x8, 0xC; `if_id_valid` rises 1 cycle after reset release with `if_id_pc4`=0x4.
- Branch: `if_id_pc4`=0x14, `br_taken`=1, `br_imm`=16'hFFFC -> next `pc`=0x4, IF/ID bubble, then instr@0x4 with `if_id_pc4`=0x8.
- Jump: `if_id_pc4`=0x1000_0008, `j_en`=1, `j_index`=26'h40 -> `pc`=0x1000_0100. `jr_en` with `jr_target`=0x0000_0203 -> `pc`=0x0000_0200.
- Stall 3 cycles at `pc`=0x20 -> `pc` and IF/ID unchanged for 3 edges, then `pc`=0x24. Stall plus `br_taken` in the same cycle -> branch taken.
- Wrap: force `pc`=0xFFFF_FFFC via `jr` -> next `pc`=0x0, `if_id_pc4`=0x0. Assert `rst` during a redirect -> `pc`=RESET_PC, `if_id_valid`=0.
- With `FETCH_PERF_CNT_EN`: 10 sequential fetches, 2 branches, 1 stall -> `fetch_count`=10, `redirect_count`=2.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared across the MIPS core front end.
//   NOP_INSTR          - instruction word used for IF/ID bubbles (sll $0,$0,0)
//   DEFAULT_RESET_PC   - default reset vector for the fetch unit
//   SEL_*              - next-PC source select encoding
//   branch_offset()    - sign-extended word immediate converted to a byte offset
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [2:0] SEL_SEQ    = 3'd0;
  localparam logic [2:0] SEL_HOLD   = 3'd1;
  localparam logic [2:0] SEL_BRANCH = 3'd2;
  localparam logic [2:0] SEL_JUMP   = 3'd3;
  localparam logic [2:0] SEL_JR     = 3'd4;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: combinational next-PC priority encoder and target arithmetic.
// Priority (high to low): jr_en > j_en > br_taken > stall > sequential.
// Reset is handled by the register owner, not here.
// Ports:
//   pc         in  32  current fetch address
//   if_id_pc4  in  32  PC+4 of the instruction currently in ID
//   stall      in  1   hold request
//   br_taken   in  1   conditional branch taken
//   br_imm     in  16  branch word offset
//   j_en       in  1   j/jal
//   j_index    in  26  jump index
//   jr_en      in  1   jr/jalr
//   jr_target  in  32  register target for jr
//   sel        out 3   selected source (SEL_* encoding)
//   next_pc    out 32  PC for the next edge
//   pc_plus4   out 32  pc + 4 (also the IF/ID pc4 value of the fetched word)
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] if_id_pc4,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        j_en,
  input  logic [25:0] j_index,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  output logic [2:0]  sel,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] jr_aligned;
  logic [31:0] jump_target;
  logic [31:0] branch_target;

  // 32-bit adds wrap naturally, giving the modulo-2^32 behaviour.
  assign pc_plus4      = pc + 32'd4;
  assign jr_aligned    = jr_target & 32'hFFFF_FFFC;
  assign jump_target   = {if_id_pc4[31:28], j_index, 2'b00};
  assign branch_target = if_id_pc4 + branch_offset(br_imm);

  always_comb begin
    sel = SEL_SEQ;
    if (jr_en) begin
      sel = SEL_JR;
    end else if (j_en) begin
      sel = SEL_JUMP;
    end else if (br_taken) begin
      sel = SEL_BRANCH;
    end else if (stall) begin
      sel = SEL_HOLD;
    end
  end

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      SEL_JR:     next_pc = jr_aligned;
      SEL_JUMP:   next_pc = jump_target;
      SEL_BRANCH: next_pc = branch_target;
      SEL_HOLD:   next_pc = pc;
      default:    next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Holds the PC and the IF/ID pipeline
// register; next-PC selection lives in next_pc_sel.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch_count/redirect_count.
// Ports:
//   clk            in  1   rising-edge clock
//   rst            in  1   synchronous active-high reset
//   stall          in  1   freeze PC and IF/ID
//   flush          in  1   bubble into IF/ID at next edge
//   br_taken       in  1   branch in ID taken
//   br_imm         in  16  branch word offset
//   j_en           in  1   j/jal in ID
//   j_index        in  26  jump index
//   jr_en          in  1   jr/jalr in ID
//   jr_target      in  32  jr register value
//   imem_instr     in  32  instruction at pc (combinational memory)
//   pc             out 32  fetch address
//   if_id_instr    out 32  registered instruction
//   if_id_pc4      out 32  registered fetch PC + 4
//   if_id_valid    out 1   IF/ID holds a real instruction
//   fetch_count    out 32  (FETCH_PERF_CNT_EN) valid loads into IF/ID
//   redirect_count out 32  (FETCH_PERF_CNT_EN) redirect edges
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        j_en,
  input  logic [25:0] j_index,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] redirect_count
`endif
);

  logic [31:0] pc_reg;
  logic [31:0] if_id_instr_reg;
  logic [31:0] if_id_pc4_reg;
  logic        if_id_valid_reg;

  logic [2:0]  sel;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        load;

  next_pc_sel u_next_pc_sel (
    .pc        (pc_reg),
    .if_id_pc4 (if_id_pc4_reg),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_imm    (br_imm),
    .j_en      (j_en),
    .j_index   (j_index),
    .jr_en     (jr_en),
    .jr_target (jr_target),
    .sel       (sel),
    .next_pc   (pc_next),
    .pc_plus4  (pc_plus4)
  );

  assign redirect = (sel == SEL_JR) || (sel == SEL_JUMP) || (sel == SEL_BRANCH);
  // A real instruction enters IF/ID only when nothing squashes or freezes it.
  assign load     = !redirect && !flush && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      if_id_instr_reg <= NOP_INSTR;
      if_id_pc4_reg   <= 32'h0;
      if_id_valid_reg <= 1'b0;
    end else begin
      pc_reg <= pc_next;
      // No delay slot: the wrong-path word fetched alongside a redirect is dropped.
      if (redirect || flush) begin
        if_id_instr_reg <= NOP_INSTR;
        if_id_pc4_reg   <= 32'h0;
        if_id_valid_reg <= 1'b0;
      end else if (load) begin
        if_id_instr_reg <= imem_instr;
        if_id_pc4_reg   <= pc_plus4;
        if_id_valid_reg <= 1'b1;
      end
    end
  end

  assign pc          = pc_reg;
  assign if_id_instr = if_id_instr_reg;
  assign if_id_pc4   = if_id_pc4_reg;
  assign if_id_valid = if_id_valid_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_reg;
  logic [31:0] redirect_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_reg    <= 32'h0;
      redirect_count_reg <= 32'h0;
    end else begin
      if (load) begin
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
      if (redirect) begin
        redirect_count_reg <= redirect_count_reg + 32'd1;
      end
    end
  end

  assign fetch_count    = fetch_count_reg;
  assign redirect_count = redirect_count_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, hand sequences and randomized stimulus
// for fetch_unit, checked against a behavioural model of the fetch stage.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        br_taken;
  logic [15:0] br_imm;
  logic        j_en;
  logic [25:0] j_index;
  logic        jr_en;
  logic [31:0] jr_target;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;
`endif

  always #5 clk = ~clk;

  // Instruction memory contents: never zero for word-aligned addresses,
  // so bubbles are distinguishable from fetched words.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  assign imem_instr = imem_word(pc);

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .br_taken       (br_taken),
    .br_imm         (br_imm),
    .j_en           (j_en),
    .j_index        (j_index),
    .jr_en          (jr_en),
    .jr_target      (jr_target),
    .imem_instr     (imem_instr),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count),
`endif
    .if_id_valid    (if_id_valid)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pc4 = 32'h0;
  logic        m_valid = 1'b0;
  logic [31:0] m_fc = 32'h0;
  logic [31:0] m_rc = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One edge: drive inputs, advance the model by the fetch-stage rules,
  // then compare every output one time unit after the edge.
  task automatic apply(input bit r, input bit s, input bit f, input bit b,
                       input logic [15:0] imm, input bit j, input logic [25:0] idx,
                       input bit jr, input logic [31:0] jt, input string tag);
    logic [31:0] n_pc, n_instr, n_pc4, n_fc, n_rc, tgt;
    logic        n_valid;
    rst = r; stall = s; flush = f; br_taken = b; br_imm = imm;
    j_en = j; j_index = idx; jr_en = jr; jr_target = jt;
    n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid;
    n_fc = m_fc; n_rc = m_rc;
    if (jr)     tgt = (jt / 4) * 4;
    else if (j) tgt = {m_pc4[31:28], 28'h0} + {4'h0, idx, 2'b00};
    else        tgt = m_pc4 + 32'($signed(imm)) * 32'd4;
    if (r) begin
      n_pc = 32'h0; n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
      n_fc = 32'h0; n_rc = 32'h0;
    end else if (jr || j || b) begin
      n_pc = tgt; n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
      n_rc = m_rc + 1;
    end else begin
      if (!s) n_pc = m_pc + 4;
      if (f) begin
        n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
      end else if (!s) begin
        n_instr = imem_word(m_pc); n_pc4 = m_pc + 4; n_valid = 1'b1;
        n_fc = m_fc + 1;
      end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid;
    m_fc = n_fc; m_rc = n_rc;
    $display("%s: rst=%0b stall=%0b flush=%0b br=%0b j=%0b jr=%0b -> pc=%h instr=%h pc4=%h valid=%0b",
             tag, r, s, f, b, j, jr, pc, if_id_instr, if_id_pc4, if_id_valid);
    check({tag, " pc"}, pc, m_pc);
    check({tag, " instr"}, if_id_instr, m_instr);
    check({tag, " pc4"}, if_id_pc4, m_pc4);
    check({tag, " valid"}, {31'h0, if_id_valid}, {31'h0, m_valid});
`ifdef FETCH_PERF_CNT_EN
    check({tag, " fetch_count"}, fetch_count, m_fc);
    check({tag, " redirect_count"}, redirect_count, m_rc);
`endif
  endtask

  typedef struct {
    bit          rst, stall, flush, br, j, jr;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] jt;
    logic [31:0] e_pc, e_pc4;
    bit          e_valid;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input bit r, input bit s, input bit f, input bit b,
                              input logic [15:0] imm, input bit j, input logic [25:0] idx,
                              input bit jr, input logic [31:0] jt,
                              input logic [31:0] e_pc, input logic [31:0] e_pc4, input bit e_valid);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.br = b; v.imm = imm; v.j = j;
    v.idx = idx; v.jr = jr; v.jt = jt; v.e_pc = e_pc; v.e_pc4 = e_pc4; v.e_valid = e_valid;
    return v;
  endfunction

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_imm = 16'h0;
    j_en = 1'b0; j_index = 26'h0; jr_en = 1'b0; jr_target = 32'h0;

    //            rst s f br imm       j idx     jr target         e_pc          e_pc4         v
    vq.push_back(mk(1, 0,0,0, 16'h0,    0,26'h0,  0,32'h0,         32'h0,        32'h0,        0)); // reset
    vq.push_back(mk(0, 0,0,0, 16'h0,    0,26'h0,  0,32'h0,         32'h4,        32'h4,        1));
    vq.push_back(mk(0, 0,0,0, 16'h0,    0,26'h0,  0,32'h0,         32'h8,        32'h8,        1));
    vq.push_back(mk(0, 0,0,0, 16'h0,    0,26'h0,  0,32'h0,         32'hC,        32'hC,        1));
    vq.push_back(mk(0, 0,0,0, 16'h0,    0,26'h0,  0,32'h0,         32'h10,       32'h10,       1));
    vq.push_back(mk(0, 0,0,0, 16'h0,    0,26'h0,  0,32'h0,         32'h14,       32'h14,       1));
    vq.push_back(mk(0, 0,0,1, 16'hFFFC, 0,26'h0,  0,32'h0,         32'h4,        32'h0,        0)); // backward branch
    vq.push_back(mk(0, 0,0,0, 16'h0,    0,26'h0,  0,32'h0,         32'h8,        32'h8,        1)); // target in IF/ID
    vq.push_back(mk(0, 0,0,0, 16'h0,    0,26'h0,  1,32'h1000_0004, 32'h1000_0004,32'h0,        0));
    vq.push_back(mk(0, 0,0,0, 16'h0,    0,26'h0,  0,32'h0,         32'h1000_0008,32'h1000_0008,1));
    vq.push_back(mk(0, 0,0,0, 16'h0,    1,26'h40, 0,32'h0,         32'h1000_0100,32'h0,        0)); // j
    vq.push_back(mk(0, 0,0,0, 16'h0,    0,26'h0,  1,32'h203,       32'h200,      32'h0,        0)); // jr, low bits dropped
    vq.push_back(mk(0, 0,0,0, 16'h0,    0,26'h0,  0,32'h0,         32'h204,      32'h204,      1));
    vq.push_back(mk(0, 0,0,0, 16'h0,    0,26'h0,  1,32'h1C,        32'h1C,       32'h0,        0));
    vq.push_back(mk(0, 0,0,0, 16'h0,    0,26'h0,  0,32'h0,         32'h20,       32'h20,       1));
    vq.push_back(mk(0, 1,0,0, 16'h0,    0,26'h0,  0,32'h0,         32'h20,       32'h20,       1)); // stall x3
    vq.push_back(mk(0, 1,0,0, 16'h0,    0,26'h0,  0,32'h0,         32'h20,       32'h20,       1));
    vq.push_back(mk(0, 1,0,0, 16'h0,    0,26'h0,  0,32'h0,         32'h20,       32'h20,       1));
    vq.push_back(mk(0, 0,0,0, 16'h0,    0,26'h0,  0,32'h0,         32'h24,       32'h24,       1));
    vq.push_back(mk(0, 1,0,1, 16'h0002, 0,26'h0,  0,32'h0,         32'h2C,       32'h0,        0)); // branch beats stall
    vq.push_back(mk(0, 0,0,0, 16'h0,    0,26'h0,  0,32'h0,         32'h30,       32'h30,       1));
    vq.push_back(mk(0, 0,0,0, 16'h0,    0,26'h0,  1,32'hFFFF_FFFE, 32'hFFFF_FFFC,32'h0,        0));
    vq.push_back(mk(0, 0,0,0, 16'h0,    0,26'h0,  0,32'h0,         32'h0,        32'h0,        1)); // wrap
    vq.push_back(mk(0, 0,1,0, 16'h0,    0,26'h0,  0,32'h0,         32'h4,        32'h0,        0)); // flush
    vq.push_back(mk(1, 0,0,0, 16'h0,    1,26'h5,  0,32'h0,         32'h0,        32'h0,        0)); // rst over j
    vq.push_back(mk(0, 0,0,0, 16'h0,    0,26'h0,  0,32'h0,         32'h4,        32'h4,        1));

    foreach (vq[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      apply(vq[i].rst, vq[i].stall, vq[i].flush, vq[i].br, vq[i].imm,
            vq[i].j, vq[i].idx, vq[i].jr, vq[i].jt, tag);
      check({tag, " exp_pc"}, pc, vq[i].e_pc);
      check({tag, " exp_pc4"}, if_id_pc4, vq[i].e_pc4);
      check({tag, " exp_valid"}, {31'h0, if_id_valid}, {31'h0, vq[i].e_valid});
      check({tag, " exp_instr"}, if_id_instr,
            vq[i].e_valid ? imem_word(vq[i].e_pc4 - 32'd4) : 32'h0);
    end

    // Redirect timing: target word reaches IF/ID exactly two edges after the request.
    apply(0, 0,0,0, 16'h0, 0,26'h0, 1,32'h0000_0400, "seq_jr");
    check("seq_jr bubble", if_id_instr, 32'h0);
    apply(0, 0,0,0, 16'h0, 0,26'h0, 0,32'h0, "seq_jr_n2");
    check("seq_jr target instr", if_id_instr, imem_word(32'h0000_0400));

`ifdef FETCH_PERF_CNT_EN
    // 10 sequential fetches, 1 stall, 2 branches.
    apply(1, 0,0,0, 16'h0, 0,26'h0, 0,32'h0, "perf_rst");
    check("perf reset fetch_count", fetch_count, 32'h0);
    check("perf reset redirect_count", redirect_count, 32'h0);
    for (int i = 0; i < 10; i++) apply(0, 0,0,0, 16'h0, 0,26'h0, 0,32'h0, "perf_seq");
    apply(0, 1,0,0, 16'h0, 0,26'h0, 0,32'h0, "perf_stall");
    apply(0, 0,0,1, 16'h0010, 0,26'h0, 0,32'h0, "perf_br0");
    apply(0, 0,0,1, 16'h0004, 0,26'h0, 0,32'h0, "perf_br1");
    check("perf fetch_count", fetch_count, 32'd10);
    check("perf redirect_count", redirect_count, 32'd2);
`endif

    // Randomized stream against the model.
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            16'($urandom), $urandom_range(0, 11) == 0, 26'($urandom),
            $urandom_range(0, 11) == 0, $urandom, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
